mul_hilo_unit: RTL and testbench
================================

MUL_HILO_UNIT -- requirements
Module: mul_hilo_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; HI and LO are each WIDTH bits.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  one-cycle request to begin a multiply.
REQ-005 The block SHALL have port ALUOperation  input  3  decoded ALU operation; 3'b100 = multiply.
REQ-006 The block SHALL have port Funct  input  6  R-type function field; 6'd1 = multiply-accumulate, 6'd25 = multiply.
REQ-007 The block SHALL have port sel  input  2  HI/LO read select; 2'b01 = mfhi, 2'b10 = mflo.
REQ-008 The block SHALL have port a  input  WIDTH  multiplicand, unsigned.
REQ-009 The block SHALL have port b  input  WIDTH  multiplier, unsigned.
REQ-010 The block SHALL have port dout  output  WIDTH  HI/LO read data.
REQ-011 The block SHALL have port busy  output  1  high while a multiply is in progress.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse when the HI/LO update is complete.
REQ-013 The block SHALL have port stall  output  1  pipeline hold request for an mfhi/mflo issued during busy.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, MUL and DONE.
REQ-015 In IDLE, a start sampled at 1 with ALUOperation==3'b100 SHALL capture a, b and mode, load the cycle counter with 0, and move the block to MUL.
REQ-016 Mode SHALL be accumulate when Funct==6'd1; any other Funct value SHALL select plain multiply.
REQ-017 In MUL, the block SHALL perform one shift-add step per cycle for exactly WIDTH cycles, forming a 2*WIDTH-bit unsigned product.
REQ-018 On the edge that ends the last MUL cycle, the block SHALL write {HI,LO} with the product (multiply) or with ({HI,LO}+product) mod 2^(2*WIDTH) (accumulate), and move to DONE.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE; done SHALL be 1 exactly WIDTH+1 cycles after the accepting edge.
REQ-020 busy SHALL be 1 in MUL only and 0 in IDLE and DONE.
REQ-021 A start arriving in MUL or DONE, or with ALUOperation!=3'b100, SHALL be ignored, with no state or register change.
REQ-022 dout SHALL be combinational: HI when sel==2'b01, LO when sel==2'b10, and 0 when sel is 2'b00 or 2'b11.
REQ-023 stall SHALL equal busy AND (sel==2'b01 OR sel==2'b10); during a stall, dout SHALL show the pre-update HI/LO values.
REQ-024 In DONE, dout SHALL already reflect the updated HI/LO values.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL clear HI, LO, the counter and the captured operands, set the state to IDLE, and drive busy=0 and done=0.
REQ-026 A reset during MUL or DONE SHALL abort the operation with no HI/LO update, and reset SHALL take priority over start in the same cycle.

Configuration
REQ-027 With macro MUL_HILO_MADD_EN defined, the block SHALL implement accumulate mode as in REQ-016 and REQ-018.
REQ-028 Without MUL_HILO_MADD_EN, Funct==6'd1 SHALL be treated as plain multiply, and the accumulate adder SHALL be absent from the design.

Structure
REQ-029 Package mul_hilo_pkg SHALL hold the ALU_mul code, the F_mul/F_mad function codes, the sel codes (SEL_NONE, SEL_HI, SEL_LO) and the state enum.
REQ-030 The shift-add datapath (product register and counter) SHALL be a sub-module named mul_shift_add; the FSM, HI/LO registers and read mux SHALL stay in mul_hilo_unit.

Verification
REQ-031 Reset: assert rst for 2 cycles -> HI=LO=0, dout=0 for every sel value, busy=0, done=0, stall=0.
REQ-032 Multiply: a=0xFFFFFFFF, b=0xFFFFFFFF, Funct=25 -> done exactly 33 cycles after start, HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 Accumulate: from HI:LO=0xFFFFFFFE:00000001, a=2, b=3, Funct=1 -> HI=0xFFFFFFFE, LO=0x00000007 with MUL_HILO_MADD_EN defined; HI=0, LO=6 without it.
REQ-034 Wrap: from HI:LO=0xFFFFFFFF:FFFFFFFF, accumulate with a=1, b=1 -> HI=0, LO=0.
REQ-035 Stall: sel=2'b01 held from start -> stall=1 for cycles 1..32 with dout equal to the old HI, then stall=0 and dout equal to the new HI in DONE.
REQ-036 Abort and ignore: a second start at cycle 5 -> ignored, with the result matching a single multiply; rst at cycle 10 -> busy=0, no done pulse, HI=LO=0.

Source files
------------

// File: rtl/mul_hilo_pkg.sv
// Shared codes and FSM state type for the HI/LO multiply unit.
// The optional multiply-accumulate mode is controlled by macro MUL_HILO_MADD_EN.
package mul_hilo_pkg;

  localparam logic [2:0] ALU_mul = 3'b100;

  localparam logic [5:0] F_mad = 6'd1;
  localparam logic [5:0] F_mul = 6'd25;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_HI   = 2'b01;
  localparam logic [1:0] SEL_LO   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier: one partial product per step, WIDTH steps.
// Holds the captured operands, the running product and the step counter.
module mul_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] partial;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // product is the running sum including the current step, so on the last
  // step it is already the complete result the parent writes into HI/LO.
  assign partial = mplier_q[0] ? mcand_q : '0;
  assign product = prod_q + partial;
  assign last    = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    // NOTE: every signal gets a default here so no latch is inferred on paths
    // that do not assign it.
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
      cnt_d    = '0;
    end else if (step) begin
      prod_d   = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update
    // together on the edge, independent of statement order.
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mul_hilo_unit.sv
// HI/LO multiply unit: FSM, HI/LO registers and read mux around mul_shift_add.
// Define MUL_HILO_MADD_EN to enable multiply-accumulate (Funct == F_mad).
module mul_hilo_unit
  import mul_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUOperation,
  input  logic [5:0]       Funct,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               load, step, last;
  logic [2*WIDTH-1:0] product, result;

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .a       (a),
    .b       (b),
    .product (product),
    .last    (last)
  );

`ifdef MUL_HILO_MADD_EN
  logic mode_q, mode_d;

  assign mode_d = load ? (Funct == F_mad) : mode_q;
  // Accumulate wraps modulo 2^(2*WIDTH); the carry out is dropped by width.
  assign result = mode_q ? ({hi_q, lo_q} + product) : product;

  always_ff @(posedge clk) begin
    if (rst) mode_q <= 1'b0;
    else     mode_q <= mode_d;
  end
`else
  logic unused_funct;

  assign unused_funct = ^Funct;
  assign result       = product;
`endif

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (ALUOperation == ALU_mul)) begin
          load    = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        step = 1'b1;
        if (last) begin
          {hi_d, lo_d} = result;
          state_d      = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MUL);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    case (sel)
      SEL_HI:  dout = hi_q;
      SEL_LO:  dout = lo_q;
      default: dout = '0;
    endcase
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = busy_q && ((sel == SEL_HI) || (sel == SEL_LO));

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed self-checking bench for mul_hilo_unit; expectations follow MUL_HILO_MADD_EN.
module tb_mul_hilo_unit;
  import mul_hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  ALUOperation;
  logic [5:0]  Funct;
  logic [1:0]  sel;
  logic [31:0] a, b;
  logic [31:0] dout;
  logic        busy, done, stall;

  int n_checks = 0;
  int n_fail   = 0;

  mul_hilo_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ALUOperation (ALUOperation),
    .Funct        (Funct),
    .sel          (sel),
    .a            (a),
    .b            (b),
    .dout         (dout),
    .busy         (busy),
    .done         (done),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a start for one cycle; returns at the falling edge of cycle 1.
  task automatic start_op(input logic [31:0] aa, input logic [31:0] bb, input logic [5:0] fn);
    @(negedge clk);
    a = aa; b = bb; Funct = fn; ALUOperation = ALU_mul; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; lat is the cycle index, counting from 'from'.
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    sel = SEL_HI;   #1 hi = dout;
    sel = SEL_LO;   #1 lo = dout;
    sel = SEL_NONE; #1;
  endtask

  initial begin
    logic [31:0] hi, lo;
    int lat;
    int n_done;

    rst = 1'b1; start = 1'b0; ALUOperation = 3'b000; Funct = 6'd0;
    sel = SEL_NONE; a = '0; b = '0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1 check($sformatf("rst_dout_sel%0d", s), dout, 32'h0);
      check($sformatf("rst_stall_sel%0d", s), {31'b0, stall}, 32'h0);
    end
    sel = SEL_NONE;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);

    // start with a non-multiply ALU operation is ignored
    @(negedge clk);
    a = 32'd3; b = 32'd4; Funct = F_mul; ALUOperation = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("nonmul_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    check("nonmul_done", {31'b0, done}, 32'h0);
    read_hilo(hi, lo);
    check("nonmul_hi", hi, 32'h0);
    check("nonmul_lo", lo, 32'h0);

    // Full-scale multiply with mfhi held: stall window and latency
    sel = SEL_HI;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, F_mul);
    for (int cyc = 1; cyc <= 32; cyc++) begin
      check($sformatf("stall_c%0d", cyc), {31'b0, stall}, 32'h1);
      check($sformatf("stall_dout_c%0d", cyc), dout, 32'h0);
      if (cyc == 32) check("done_early_c32", {31'b0, done}, 32'h0);
      @(negedge clk);
    end
    check("c33_done", {31'b0, done}, 32'h1);
    check("c33_stall", {31'b0, stall}, 32'h0);
    check("c33_busy", {31'b0, busy}, 32'h0);
    check("c33_dout_hi", dout, 32'hFFFF_FFFE);
    sel = SEL_LO;
    #1 check("c33_dout_lo", dout, 32'h0000_0001);
    sel = SEL_NONE;
    @(negedge clk);
    check("done_pulse_end", {31'b0, done}, 32'h0);

    // Accumulate 2*3 onto FFFFFFFE:00000001
    start_op(32'd2, 32'd3, F_mad);
    wait_done(1, lat);
    check("mad1_latency", 32'(lat), 32'd33);
    read_hilo(hi, lo);
`ifdef MUL_HILO_MADD_EN
    check("mad1_hi", hi, 32'hFFFF_FFFE);
    check("mad1_lo", lo, 32'h0000_0007);
`else
    check("mad1_hi", hi, 32'h0);
    check("mad1_lo", lo, 32'h6);
`endif

    // Accumulate 2*FFFFFFFC to reach all-ones (MADD build)
    start_op(32'd2, 32'hFFFF_FFFC, F_mad);
    wait_done(1, lat);
    read_hilo(hi, lo);
`ifdef MUL_HILO_MADD_EN
    check("mad2_hi", hi, 32'hFFFF_FFFF);
    check("mad2_lo", lo, 32'hFFFF_FFFF);
`else
    check("mad2_hi", hi, 32'h0000_0001);
    check("mad2_lo", lo, 32'hFFFF_FFF8);
`endif

    // Accumulate 1*1: wraps to zero
    start_op(32'd1, 32'd1, F_mad);
    wait_done(1, lat);
    read_hilo(hi, lo);
`ifdef MUL_HILO_MADD_EN
    check("wrap_hi", hi, 32'h0);
    check("wrap_lo", lo, 32'h0);
`else
    check("wrap_hi", hi, 32'h0);
    check("wrap_lo", lo, 32'h1);
`endif

    // Second start at cycle 5 is ignored
    start_op(32'h0001_0000, 32'h0003_0000, F_mul);
    repeat (4) @(negedge clk);
    check("ign_busy_c5", {31'b0, busy}, 32'h1);
    a = 32'd7; b = 32'd9; Funct = F_mad; ALUOperation = ALU_mul; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat);
    check("ign_latency", 32'(lat), 32'd33);
    read_hilo(hi, lo);
    check("ign_hi", hi, 32'h0000_0003);
    check("ign_lo", lo, 32'h0000_0000);

    // Reset wins over a simultaneous start and clears HI/LO
    @(negedge clk);
    rst = 1'b1; a = 32'd5; b = 32'd5; Funct = F_mul; ALUOperation = ALU_mul; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rstprio_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    check("rstprio_busy2", {31'b0, busy}, 32'h0);
    read_hilo(hi, lo);
    check("rstprio_hi", hi, 32'h0);
    check("rstprio_lo", lo, 32'h0);

    // Reset at cycle 10 aborts the multiply
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, F_mul);
    repeat (9) @(negedge clk);
    check("abort_busy_c10", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'h0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    read_hilo(hi, lo);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
